// File: rtl/sdram_ioctl_upload_if.sv
// sdram_ioctl_upload_if: hps_io upload port plus SDRAM read channel.
// slave is the uploader's view, master is the surrounding system's view.
interface sdram_ioctl_upload_if;
  logic        ioctl_upload;
  logic [26:0] ioctl_addr;
  logic        ioctl_rd;
  logic [15:0] ioctl_din;
  logic        ioctl_wait;
  logic [26:0] sdram_addr;
  logic        sdram_req;
  logic        sdram_rnw;
  logic [31:0] sdram_dout;
  logic        sdram_ready;
  logic        busy;

  modport slave (
    input  ioctl_upload, ioctl_addr, ioctl_rd,
    input  sdram_dout, sdram_ready,
    output ioctl_din, ioctl_wait,
    output sdram_addr, sdram_req, sdram_rnw, busy
  );

  modport master (
    output ioctl_upload, ioctl_addr, ioctl_rd,
    output sdram_dout, sdram_ready,
    input  ioctl_din, ioctl_wait,
    input  sdram_addr, sdram_req, sdram_rnw, busy
  );
endinterface

// File: rtl/sdram_ioctl_upload.sv
// sdram_ioctl_upload: serves hps_io upload reads from SDRAM via a one-word cache.
// Optional next-word background prefetch: define UPLOAD_PREFETCH_EN.
module sdram_ioctl_upload #(
  parameter logic [26:0] BASE_ADDR  = 27'd0,
  parameter int unsigned SIZE_BYTES = 131072,
  parameter logic [15:0] FILL_VALUE = 16'hFFFF
) (
  input logic clk1x,
  input logic reset,
  sdram_ioctl_upload_if.slave bus
);

`ifdef UPLOAD_PREFETCH_EN
  localparam bit PF_EN = 1'b1;
`else
  localparam bit PF_EN = 1'b0;
`endif

  localparam logic [32:0] SIZE = 33'(SIZE_BYTES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DRAIN,
    S_PF
  } state_t;

  state_t state, state_d;

  logic        upload_q;
  logic        cache_valid, cache_valid_d;
  logic [24:0] cache_tag, cache_tag_d;
  logic [31:0] cache_word, cache_word_d;
  logic [24:0] req_tag, req_tag_d;
  logic        req_half, req_half_d;
  logic        pend_valid, pend_valid_d;
  logic [26:0] pend_addr, pend_addr_d;
  logic [15:0] din, din_d;
  logic        stall, stall_d;
  logic        req, req_d;
  logic [26:0] addr, addr_d;
  logic        busy, busy_d;

  logic        upload, rd, ready, rise;
  logic [26:0] rd_addr;
  logic [31:0] dout;

  logic        sv;
  logic [26:0] sv_addr;
  logic [24:0] sv_tag;
  logic        sv_oow, sv_hit, sv_miss;
  logic [15:0] sv_half;
  logic        cv_valid;
  logic [24:0] cv_tag;
  logic [31:0] cv_word;

  logic        pf_hit, pf_fill, pf_go;
  logic [24:0] pf_tag;

  assign upload  = bus.ioctl_upload;
  assign rd      = bus.ioctl_rd;
  assign rd_addr = bus.ioctl_addr;
  assign ready   = bus.sdram_ready;
  assign dout    = bus.sdram_dout;
  assign rise    = upload & ~upload_q;

  assign bus.ioctl_din  = din;
  assign bus.ioctl_wait = stall;
  assign bus.sdram_addr = addr;
  assign bus.sdram_req  = req;
  assign bus.sdram_rnw  = 1'b1;
  assign bus.busy       = busy;

  function automatic logic next_in_win(input logic [24:0] tag);
    logic [25:0] nxt;
    nxt = {1'b0, tag} + 26'd1;
    return {5'd0, nxt, 2'b00} < SIZE;
  endfunction

  function automatic logic [26:0] word_addr(input logic [24:0] tag);
    return BASE_ADDR + {tag, 2'b00};
  endfunction

  // pick the read being served this cycle: a fresh strobe or one held over a drain/prefetch
  always_comb begin
    sv = 1'b0;
    sv_addr = rd_addr;
    unique case (state)
      S_IDLE: sv = rd & upload;
      S_DRAIN, S_PF: begin
        sv = ready & upload & (pend_valid | rd);
        sv_addr = pend_valid ? pend_addr : rd_addr;
      end
      default: sv = 1'b0;
    endcase
  end

  // cache view: a completing prefetch counts as already cached
  always_comb begin
    if (state == S_PF && ready) begin
      cv_valid = 1'b1;
      cv_tag = req_tag;
      cv_word = dout;
    end else begin
      cv_valid = cache_valid & upload & ~rise;
      cv_tag = cache_tag;
      cv_word = cache_word;
    end
  end

  assign sv_tag  = sv_addr[26:2];
  assign sv_oow  = {6'd0, sv_addr} >= SIZE;
  assign sv_hit  = cv_valid && (cv_tag == sv_tag);
  assign sv_miss = sv && !sv_oow && !sv_hit;
  assign sv_half = sv_addr[1] ? cv_word[31:16] : cv_word[15:0];

  assign pf_hit  = PF_EN && sv && !sv_oow && sv_hit
                   && sv_addr[1] && next_in_win(sv_tag);
  assign pf_fill = PF_EN && state == S_WAIT && upload && ready
                   && req_half && next_in_win(req_tag);
  assign pf_go   = pf_hit || pf_fill;
  assign pf_tag  = (pf_hit ? sv_tag : req_tag) + 25'd1;

  // state register
  always_ff @(posedge clk1x) begin
    if (reset) state <= S_IDLE;
    else       state <= state_d;
  end

  // next-state decode
  always_comb begin
    state_d = state;
    unique case (state)
      S_IDLE: begin
        if (sv_miss)    state_d = S_WAIT;
        else if (pf_go) state_d = S_PF;
      end
      S_WAIT: begin
        if (!upload)    state_d = ready ? S_IDLE : S_DRAIN;
        else if (ready) state_d = pf_go ? S_PF : S_IDLE;
      end
      S_DRAIN: begin
        if (ready) state_d = sv_miss ? S_WAIT : S_IDLE;
      end
      S_PF: begin
        if (!upload)      state_d = ready ? S_IDLE : S_DRAIN;
        else if (ready) begin
          if (sv_miss)    state_d = S_WAIT;
          else if (pf_go) state_d = S_PF;
          else            state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // next values of outputs, cache and held request
  always_comb begin
    din_d = din;
    stall_d = stall;
    req_d = 1'b0;
    addr_d = addr;
    busy_d = busy;
    cache_valid_d = cache_valid;
    cache_tag_d = cache_tag;
    cache_word_d = cache_word;
    req_tag_d = req_tag;
    req_half_d = req_half;
    pend_valid_d = pend_valid;
    pend_addr_d = pend_addr;
    unique case (state)
      S_WAIT: begin
        if (!upload) begin
          stall_d = 1'b0;
          busy_d = ~ready;
        end else if (ready) begin
          cache_valid_d = 1'b1;
          cache_tag_d = req_tag;
          cache_word_d = dout;
          din_d = req_half ? dout[31:16] : dout[15:0];
          stall_d = 1'b0;
          busy_d = 1'b0;
        end
      end
      S_DRAIN: begin
        if (ready) busy_d = 1'b0;
        if (!upload) begin
          stall_d = 1'b0;
          pend_valid_d = 1'b0;
        end else if (rd && !pend_valid) begin
          pend_valid_d = 1'b1;
          pend_addr_d = rd_addr;
          stall_d = 1'b1;
        end
      end
      S_PF: begin
        if (!upload) begin
          stall_d = 1'b0;
          busy_d = ~ready;
          pend_valid_d = 1'b0;
        end else begin
          if (rd && !pend_valid) begin
            pend_valid_d = 1'b1;
            pend_addr_d = rd_addr;
            stall_d = 1'b1;
          end
          if (ready) begin
            cache_valid_d = 1'b1;
            cache_tag_d = req_tag;
            cache_word_d = dout;
            busy_d = 1'b0;
          end
        end
      end
      default: begin
      end
    endcase
    if (sv) begin
      pend_valid_d = 1'b0;
      if (sv_oow) begin
        din_d = FILL_VALUE;
        stall_d = 1'b0;
      end else if (sv_hit) begin
        din_d = sv_half;
        stall_d = 1'b0;
      end else begin
        req_d = 1'b1;
        addr_d = word_addr(sv_tag);
        stall_d = 1'b1;
        busy_d = 1'b1;
        req_tag_d = sv_tag;
        req_half_d = sv_addr[1];
      end
    end
    if (pf_go) begin
      req_d = 1'b1;
      addr_d = word_addr(pf_tag);
      busy_d = 1'b1;
      req_tag_d = pf_tag;
    end
    if (!upload || rise) cache_valid_d = 1'b0;
    if (!upload) pend_valid_d = 1'b0;
  end

  // datapath registers
  always_ff @(posedge clk1x) begin
    if (reset) begin
      upload_q <= 1'b0;
      cache_valid <= 1'b0;
      cache_tag <= '0;
      cache_word <= '0;
      req_tag <= '0;
      req_half <= 1'b0;
      pend_valid <= 1'b0;
      pend_addr <= '0;
      din <= '0;
      stall <= 1'b0;
      req <= 1'b0;
      addr <= '0;
      busy <= 1'b0;
    end else begin
      upload_q <= upload;
      cache_valid <= cache_valid_d;
      cache_tag <= cache_tag_d;
      cache_word <= cache_word_d;
      req_tag <= req_tag_d;
      req_half <= req_half_d;
      pend_valid <= pend_valid_d;
      pend_addr <= pend_addr_d;
      din <= din_d;
      stall <= stall_d;
      req <= req_d;
      addr <= addr_d;
      busy <= busy_d;
    end
  end

endmodule

// File: tb/tb_sdram_ioctl_upload.sv
// tb_sdram_ioctl_upload: vector table, corner sequences and random reads
// against a transaction-level model of the upload reader.
module tb_sdram_ioctl_upload;
  localparam logic [26:0] BASE = 27'h100000;
  localparam int SIZE = 131072;
  localparam logic [31:0] SIZE_W = 32'(SIZE);

  logic clk1x = 1'b0;
  logic reset;
  always #5 clk1x = ~clk1x;

  sdram_ioctl_upload_if bus ();

  sdram_ioctl_upload #(
    .BASE_ADDR(BASE),
    .SIZE_BYTES(SIZE),
    .FILL_VALUE(16'hFFFF)
  ) dut (
    .clk1x(clk1x),
    .reset(reset),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lat = 1;
  int req_count = 0;
  bit pend = 1'b0;
  int due = 0;
  logic [26:0] paddr;
  bit mvalid = 1'b0;
  logic [24:0] mtag = '0;

  typedef struct {
    logic [26:0] addr;
    int          lat;
    logic [15:0] din;
    bit          miss;
  } vec_t;

  vec_t vt[9];

  function automatic logic [31:0] mem(input logic [26:0] a);
    if (a == 27'h100000) return 32'hA1B2C3D4;
    return {a[17:2] ^ 16'h5A5A, a[17:2] + 16'h1234};
  endfunction

  task automatic check(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", n, act, exp);
    end
  endtask

  // one clock; the SDRAM responder answers each request after lat cycles
  task automatic tick();
    @(posedge clk1x);
    #1;
    cyc++;
    bus.sdram_ready = 1'b0;
    if (bus.sdram_req) begin
      req_count++;
      pend = 1'b1;
      due = cyc + lat;
      paddr = bus.sdram_addr;
    end
    if (pend && cyc == due) begin
      bus.sdram_ready = 1'b1;
      bus.sdram_dout = mem(paddr);
      pend = 1'b0;
    end
  endtask

  task automatic set_upload(input bit v);
    bus.ioctl_upload = v;
    if (!v) mvalid = 1'b0;
  endtask

  function automatic void predict(input logic [26:0] a,
                                  output logic [15:0] e, output bit m);
    logic [31:0] w;
    w = mem(BASE + {a[26:2], 2'b00});
    if ({5'd0, a} >= SIZE_W) begin
      e = 16'hFFFF;
      m = 1'b0;
    end else begin
      e = a[1] ? w[31:16] : w[15:0];
      m = !(mvalid && mtag == a[26:2]);
    end
  endfunction

  task automatic do_read(input logic [26:0] a, input int l,
                         input logic [15:0] e, input bit m, input string n);
    int rc0;
    int st;
    lat = l;
    rc0 = req_count;
    bus.ioctl_addr = a;
    bus.ioctl_rd = 1'b1;
    tick();
    bus.ioctl_rd = 1'b0;
    if (m) begin
      check({n, " req"}, 32'(bus.sdram_req), 1);
      check({n, " sdram_addr"}, 32'(bus.sdram_addr),
            32'(BASE + {a[26:2], 2'b00}));
      check({n, " wait"}, 32'(bus.ioctl_wait), 1);
      st = 0;
      while (bus.ioctl_wait && st < 64) begin
        tick();
        st++;
      end
      check({n, " stall"}, st, l + 1);
      mvalid = 1'b1;
      mtag = a[26:2];
    end else begin
      check({n, " wait"}, 32'(bus.ioctl_wait), 0);
      check({n, " req"}, 32'(bus.sdram_req), 0);
    end
    check({n, " din"}, 32'(bus.ioctl_din), 32'(e));
    check({n, " req count"}, req_count - rc0, m ? 1 : 0);
    check({n, " busy"}, 32'(bus.busy), 0);
  endtask

  task automatic drain_sdram();
    int k;
    k = 0;
    while (pend && k < 32) begin
      tick();
      k++;
    end
    check("responder drained", 32'(pend), 0);
  endtask

  initial begin
    logic [26:0] a;
    logic [15:0] e;
    bit m;
    int rc0;
    int st;
    int r;

    reset = 1'b1;
    bus.ioctl_upload = 1'b0;
    bus.ioctl_rd = 1'b0;
    bus.ioctl_addr = '0;
    bus.sdram_ready = 1'b0;
    bus.sdram_dout = '0;
    tick();
    tick();
    check("reset din", 32'(bus.ioctl_din), 0);
    check("reset wait", 32'(bus.ioctl_wait), 0);
    check("reset req", 32'(bus.sdram_req), 0);
    check("reset addr", 32'(bus.sdram_addr), 0);
    check("reset busy", 32'(bus.busy), 0);
    check("rnw", 32'(bus.sdram_rnw), 1);
    reset = 1'b0;
    set_upload(1'b1);
    tick();

`ifdef UPLOAD_PREFETCH_EN
    rc0 = req_count;
    do_read(27'd0, 6, 16'hC3D4, 1'b1, "pf rd0");
    lat = 6;
    bus.ioctl_addr = 27'd2;
    bus.ioctl_rd = 1'b1;
    tick();
    bus.ioctl_rd = 1'b0;
    check("pf rd2 din", 32'(bus.ioctl_din), 32'hA1B2);
    check("pf rd2 wait", 32'(bus.ioctl_wait), 0);
    check("pf rd2 prefetch req", 32'(bus.sdram_req), 1);
    check("pf rd2 prefetch addr", 32'(bus.sdram_addr), 32'h100004);
    bus.ioctl_addr = 27'd4;
    bus.ioctl_rd = 1'b1;
    tick();
    bus.ioctl_rd = 1'b0;
    check("pf rd4 wait", 32'(bus.ioctl_wait), 1);
    st = 0;
    while (bus.ioctl_wait && st < 64) begin
      tick();
      st++;
    end
    check("pf rd4 stall", st, 6);
    check("pf rd4 din", 32'(bus.ioctl_din), 32'h1235);
    check("pf req count", req_count - rc0, 2);
    bus.ioctl_addr = 27'd6;
    bus.ioctl_rd = 1'b1;
    tick();
    bus.ioctl_rd = 1'b0;
    check("pf rd6 din", 32'(bus.ioctl_din), 32'h5A5B);
    check("pf rd6 wait", 32'(bus.ioctl_wait), 0);
    check("pf rd6 prefetch req", 32'(bus.sdram_req), 1);
    check("pf rd6 prefetch addr", 32'(bus.sdram_addr), 32'h100008);
    drain_sdram();
`else
    vt[0] = '{27'h0,       3, 16'hC3D4, 1'b1};
    vt[1] = '{27'h2,       3, 16'hA1B2, 1'b0};
    vt[2] = '{27'h20000,   3, 16'hFFFF, 1'b0};
    vt[3] = '{27'h1FFFE,   5, 16'h25A5, 1'b1};
    vt[4] = '{27'h1FFFF,   5, 16'h25A5, 1'b0};
    vt[5] = '{27'h1FFFC,   5, 16'h9233, 1'b0};
    vt[6] = '{27'h7FFFFFF, 2, 16'hFFFF, 1'b0};
    vt[7] = '{27'h6,       1, 16'h5A5B, 1'b1};
    vt[8] = '{27'h4,       1, 16'h1235, 1'b0};
    for (int i = 0; i < 9; i++)
      do_read(vt[i].addr, vt[i].lat, vt[i].din, vt[i].miss,
              $sformatf("vec%0d", i));

    do_read(27'd0, 2, 16'hC3D4, 1'b1, "session1 rd0");
    set_upload(1'b0);
    tick();
    tick();
    set_upload(1'b1);
    tick();
    do_read(27'd2, 2, 16'hA1B2, 1'b1, "new session rd2");

    lat = 9;
    bus.ioctl_addr = 27'd4;
    bus.ioctl_rd = 1'b1;
    tick();
    bus.ioctl_rd = 1'b0;
    check("abort req", 32'(bus.sdram_req), 1);
    check("abort wait before", 32'(bus.ioctl_wait), 1);
    set_upload(1'b0);
    tick();
    check("abort wait low", 32'(bus.ioctl_wait), 0);
    drain_sdram();
    tick();
    tick();
    set_upload(1'b1);
    tick();
    do_read(27'd4, 2, 16'h1235, 1'b1, "after abort rd4");

    lat = 4;
    bus.ioctl_addr = 27'd8;
    bus.ioctl_rd = 1'b1;
    tick();
    bus.ioctl_rd = 1'b0;
    check("rst-wait req", 32'(bus.sdram_req), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mvalid = 1'b0;
    check("rst-wait din", 32'(bus.ioctl_din), 0);
    check("rst-wait wait", 32'(bus.ioctl_wait), 0);
    check("rst-wait req low", 32'(bus.sdram_req), 0);
    check("rst-wait addr", 32'(bus.sdram_addr), 0);
    check("rst-wait busy", 32'(bus.busy), 0);
    drain_sdram();
    tick();
    tick();
    check("stray din", 32'(bus.ioctl_din), 0);
    check("stray wait", 32'(bus.ioctl_wait), 0);
    check("stray busy", 32'(bus.busy), 0);
    do_read(27'd8, 3, 16'h1236, 1'b1, "post-reset rd8");

    lat = 6;
    rc0 = req_count;
    bus.ioctl_addr = 27'd12;
    bus.ioctl_rd = 1'b1;
    tick();
    bus.ioctl_rd = 1'b0;
    check("rd-in-wait req", 32'(bus.sdram_req), 1);
    tick();
    bus.ioctl_addr = 27'h20000;
    bus.ioctl_rd = 1'b1;
    tick();
    bus.ioctl_rd = 1'b0;
    st = 0;
    while (bus.ioctl_wait && st < 64) begin
      tick();
      st++;
    end
    check("rd-in-wait stall", st, 5);
    check("rd-in-wait din", 32'(bus.ioctl_din), 32'h1237);
    check("rd-in-wait req count", req_count - rc0, 1);
    mvalid = 1'b1;
    mtag = 25'd3;

    bus.sdram_dout = 32'hDEADBEEF;
    bus.sdram_ready = 1'b1;
    tick();
    do_read(27'd14, 2, 16'h5A59, 1'b0, "idle stray ready");

    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 99);
      if (r < 60)      a = 27'($urandom_range(0, 63));
      else if (r < 85) a = 27'($urandom_range(0, SIZE - 1));
      else if (r < 93) a = 27'(SIZE - 8 + $urandom_range(0, 15));
      else             a = 27'($urandom);
      if ($urandom_range(0, 19) == 0) begin
        set_upload(1'b0);
        repeat ($urandom_range(1, 3)) tick();
        set_upload(1'b1);
        tick();
      end
      predict(a, e, m);
      do_read(a, $urandom_range(1, 8), e, m, $sformatf("rand%0d", i));
      repeat ($urandom_range(0, 3)) tick();
      check("rand din hold", 32'(bus.ioctl_din), 32'(e));
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
